// File: rtl/call_ret_ctrl.sv
// Subroutine call/return sequencer sitting between the instruction decoder
// and the return-address stack. A CALL pushes the return address and
// redirects the PC to the call target. A RET pops the stack and redirects the
// PC to the popped address. Stack overflow and underflow, and a CALL and RET
// arriving together, are latched as a sticky fault until fault_clr.
module call_ret_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int RET_OFFSET = 1,
    parameter int CNT_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              call_req,
    input  logic              ret_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] target,
    input  logic              fault_clr,
    output logic              stk_enable,
    output logic              stk_op,
    output logic [ADDR_W-1:0] stk_din,
    input  logic [ADDR_W-1:0] stk_dout,
    input  logic              stk_full,
    input  logic              stk_empty,
    output logic              busy,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_next,
    output logic [CNT_W-1:0]  depth,
    output logic              fault,
    output logic [1:0]        fault_code
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PUSH  = 3'd1,
        POP   = 3'd2,
        POPW  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] OFFS      = ADDR_W'(RET_OFFSET);
    localparam logic [CNT_W-1:0]  DEPTH_MAX = '1;
    localparam logic [CNT_W-1:0]  DEPTH_ONE = CNT_W'(1);

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_OVER  = 2'b01;
    localparam logic [1:0] CODE_UNDER = 2'b10;
    localparam logic [1:0] CODE_BOTH  = 2'b11;

    state_t            state;
    logic [ADDR_W-1:0] pc_next_q;

    // Sequencer: state, stack strobes, PC redirect, shadow depth and fault.
    // Strobe outputs are registered on entry to the state that owns them, so
    // they are high for exactly the one cycle spent in PUSH or POP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            stk_enable <= 1'b0;
            stk_op     <= 1'b0;
            stk_din    <= '0;
            pc_load    <= 1'b0;
            pc_next_q  <= '0;
            depth      <= '0;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
        end else begin
            stk_enable <= 1'b0;
            stk_op     <= 1'b0;
            stk_din    <= '0;
            pc_load    <= 1'b0;
            pc_next_q  <= '0;
            case (state)
                IDLE: begin
                    if (call_req && ret_req) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= CODE_BOTH;
                    end else if (call_req) begin
                        if (stk_full) begin
                            state      <= FAULT;
                            fault      <= 1'b1;
                            fault_code <= CODE_OVER;
                        end else begin
                            state      <= PUSH;
                            stk_enable <= 1'b1;
                            stk_op     <= 1'b1;
                            stk_din    <= pc + OFFS;
                            pc_load    <= 1'b1;
                            pc_next_q  <= target;
                        end
                    end else if (ret_req) begin
                        if (stk_empty) begin
                            state      <= FAULT;
                            fault      <= 1'b1;
                            fault_code <= CODE_UNDER;
                        end else begin
                            state      <= POP;
                            stk_enable <= 1'b1;
                            stk_op     <= 1'b0;
                        end
                    end
                end
                PUSH: begin
                    state <= IDLE;
                    if (depth != DEPTH_MAX) depth <= depth + DEPTH_ONE;
                end
                POP: begin
                    // Popped data appears on stk_dout during POPW.
                    state   <= POPW;
                    pc_load <= 1'b1;
                    if (depth != '0) depth <= depth - DEPTH_ONE;
                end
                POPW: begin
                    state <= IDLE;
                end
                FAULT: begin
                    if (fault_clr) begin
                        state      <= IDLE;
                        fault      <= 1'b0;
                        fault_code <= CODE_NONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The stack's registered read data is only valid in POPW, so it is
    // forwarded straight to pc_next there; otherwise the registered target.
    always_comb begin
        pc_next = pc_next_q;
        if (state == POPW) pc_next = stk_dout;
    end

    // Busy is a pure decode of the state register.
    always_comb begin
        busy = (state != IDLE);
    end

endmodule
